// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Values shared by the edge-detection pipeline: image geometry,
//               pixel width, pass encodings and the pixel type, so that
//               Main_Ctrl_Unit and the filter units agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int IMG_DIM    = 20;
    localparam int BIT_LENGTH = 5;

    typedef enum logic [2:0] {
        MED_FIL  = 3'd0,
        GAU_FIL  = 3'd1,
        SOBEL    = 3'd2,
        NON_MAX  = 3'd3,
        HYSTER   = 3'd4,
        QUANTIZE = 3'd5
    } op_e;

    typedef logic [BIT_LENGTH-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/med_fil_unit_sort3.sv
`default_nettype none
// ============================================================================
// Module      : sort3
// Description : Purely combinational unsigned 3-input sorter.
// Ports       : i_a, i_b, i_c  - values to sort
//               o_lo, o_mid, o_hi - minimum, median and maximum
// Revision    : 1.0 - initial release
// ============================================================================
module sort3
    import img_pkg::*;
#(
    parameter int WIDTH = BIT_LENGTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_mid,
    output logic [WIDTH-1:0] o_hi
);

    logic [WIDTH-1:0] w_ab_lo;
    logic [WIDTH-1:0] w_ab_hi;
    logic [WIDTH-1:0] w_hi_c_lo;

    assign w_ab_lo   = (i_a < i_b) ? i_a : i_b;
    assign w_ab_hi   = (i_a < i_b) ? i_b : i_a;
    assign o_lo      = (w_ab_lo < i_c) ? w_ab_lo : i_c;
    assign o_hi      = (w_ab_hi < i_c) ? i_c : w_ab_hi;
    // median = max(min(a,b), min(max(a,b), c))
    assign w_hi_c_lo = (w_ab_hi < i_c) ? w_ab_hi : i_c;
    assign o_mid     = (w_ab_lo < w_hi_c_lo) ? w_hi_c_lo : w_ab_lo;

endmodule
`default_nettype wire

// File: rtl/med_fil_unit.sv
`default_nettype none
// ============================================================================
// Module      : med_fil_unit
// Description : Streaming 3x3 median filter. Accepts one 3-pixel column per
//               cycle from a 3-row strip and emits one median per complete
//               window with a fixed 3-cycle latency and no backpressure.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               start           - one-cycle pulse opening a new strip
//               in_valid        - column present on col_top/col_mid/col_bot
//               col_top/mid/bot - rows r-2, r-1, r of the incoming column
//               out_valid       - median_out valid this cycle
//               median_out      - window median (held between results)
//               strip_done      - pulses with the strip's last out_valid
//               busy            - strip open or pipeline holding data
// Revision    : 1.0 - initial release
// ============================================================================
module med_fil_unit
    import img_pkg::*;
#(
    parameter int BIT_LENGTH = img_pkg::BIT_LENGTH,
    parameter int IMG_DIM    = img_pkg::IMG_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [BIT_LENGTH-1:0] col_top,
    input  logic [BIT_LENGTH-1:0] col_mid,
    input  logic [BIT_LENGTH-1:0] col_bot,
    output logic                  out_valid,
    output logic [BIT_LENGTH-1:0] median_out,
    output logic                  strip_done,
    output logic                  busy
);

    localparam int                 c_cnt_w     = $clog2(IMG_DIM + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full  = c_cnt_w'(IMG_DIM);
    localparam logic [c_cnt_w-1:0] c_cnt_first = c_cnt_w'(3);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fill  = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_cnt_w-1:0]    r_col_cnt;
    logic [c_cnt_w-1:0]    w_cnt_base;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic                  w_open;
    logic                  w_accept;
    logic                  w_pipe_vld;

    // window registers, indexed [column][row]; column 2 is the newest
    logic [BIT_LENGTH-1:0] r_win [3][3];
    logic                  r_win_vld;
    logic                  r_win_last;

    logic [BIT_LENGTH-1:0] w_s1_lo  [3];
    logic [BIT_LENGTH-1:0] w_s1_mid [3];
    logic [BIT_LENGTH-1:0] w_s1_hi  [3];
    logic [BIT_LENGTH-1:0] r_s1_lo  [3];
    logic [BIT_LENGTH-1:0] r_s1_mid [3];
    logic [BIT_LENGTH-1:0] r_s1_hi  [3];
    logic                  r_s1_vld;
    logic                  r_s1_last;

    logic [BIT_LENGTH-1:0] w_s2_a;
    logic [BIT_LENGTH-1:0] w_s2_b;
    logic [BIT_LENGTH-1:0] w_s2_c;
    logic [BIT_LENGTH-1:0] r_s2_a;
    logic [BIT_LENGTH-1:0] r_s2_b;
    logic [BIT_LENGTH-1:0] r_s2_c;
    logic                  r_s2_vld;
    logic                  r_s2_last;

    logic [BIT_LENGTH-1:0] w_s3_med;
    logic [BIT_LENGTH-1:0] r_median;
    logic                  r_s3_vld;
    logic                  r_s3_last;

    // sorter outputs the reductions do not need
    logic [BIT_LENGTH-1:0] w_unused [8];

    // ------------------------------------------------------------------
    // Column acceptance. A start that arrives with a column takes that
    // column as column 0 of the new strip, whatever state we were in.
    // ------------------------------------------------------------------
    assign w_open     = (r_state == c_st_fill) || (r_state == c_st_run);
    assign w_accept   = in_valid && (start || (w_open && (r_col_cnt != c_cnt_full)));
    assign w_cnt_base = start ? '0 : r_col_cnt;
    assign w_cnt_next = w_accept ? (w_cnt_base + c_cnt_w'(1)) : w_cnt_base;
    assign w_pipe_vld = r_win_vld || r_s1_vld || r_s2_vld || r_s3_vld;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = c_st_fill;
        end else begin
            case (r_state)
                c_st_fill: begin
                    if (w_accept && (w_cnt_next == c_cnt_first)) begin
                        w_state_next = c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_accept && (w_cnt_next == c_cnt_full)) begin
                        w_state_next = c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (!w_pipe_vld) begin
                        w_state_next = c_st_idle;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Column counter and window shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col_cnt  <= '0;
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_col_cnt <= w_cnt_next;
            if (w_accept) begin
                r_win[0]    <= r_win[1];
                r_win[1]    <= r_win[2];
                r_win[2][0] <= col_top;
                r_win[2][1] <= col_mid;
                r_win[2][2] <= col_bot;
            end
            // the window is complete once three columns of this strip are in
            r_win_vld  <= w_accept && (w_cnt_next >= c_cnt_first);
            r_win_last <= w_accept && (w_cnt_next == c_cnt_full);
        end
    end

    // ------------------------------------------------------------------
    // S1: sort each window column
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : g_col_sort
        sort3 #(.WIDTH(BIT_LENGTH)) u_sort (
            .i_a   (r_win[g][0]),
            .i_b   (r_win[g][1]),
            .i_c   (r_win[g][2]),
            .o_lo  (w_s1_lo[g]),
            .o_mid (w_s1_mid[g]),
            .o_hi  (w_s1_hi[g])
        );
    end

    // ------------------------------------------------------------------
    // S2: a = max of lows, b = median of mids, c = min of highs
    // ------------------------------------------------------------------
    sort3 #(.WIDTH(BIT_LENGTH)) u_s2_lo (
        .i_a(r_s1_lo[0]), .i_b(r_s1_lo[1]), .i_c(r_s1_lo[2]),
        .o_lo(w_unused[0]), .o_mid(w_unused[1]), .o_hi(w_s2_a)
    );

    sort3 #(.WIDTH(BIT_LENGTH)) u_s2_mid (
        .i_a(r_s1_mid[0]), .i_b(r_s1_mid[1]), .i_c(r_s1_mid[2]),
        .o_lo(w_unused[2]), .o_mid(w_s2_b), .o_hi(w_unused[3])
    );

    sort3 #(.WIDTH(BIT_LENGTH)) u_s2_hi (
        .i_a(r_s1_hi[0]), .i_b(r_s1_hi[1]), .i_c(r_s1_hi[2]),
        .o_lo(w_s2_c), .o_mid(w_unused[4]), .o_hi(w_unused[5])
    );

    // ------------------------------------------------------------------
    // S3: the 9-pixel median is the median of (a, b, c)
    // ------------------------------------------------------------------
    sort3 #(.WIDTH(BIT_LENGTH)) u_s3 (
        .i_a(r_s2_a), .i_b(r_s2_b), .i_c(r_s2_c),
        .o_lo(w_unused[6]), .o_mid(w_s3_med), .o_hi(w_unused[7])
    );

    // ------------------------------------------------------------------
    // Pipeline registers. start drops every in-flight window so an aborted
    // strip never produces another result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s3_vld  <= 1'b0;
            r_s3_last <= 1'b0;
            r_s2_a    <= '0;
            r_s2_b    <= '0;
            r_s2_c    <= '0;
            r_median  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_s1_lo[i]  <= '0;
                r_s1_mid[i] <= '0;
                r_s1_hi[i]  <= '0;
            end
        end else begin
            r_s1_vld  <= r_win_vld  && !start;
            r_s1_last <= r_win_last && !start;
            r_s2_vld  <= r_s1_vld   && !start;
            r_s2_last <= r_s1_last  && !start;
            r_s3_vld  <= r_s2_vld   && !start;
            r_s3_last <= r_s2_last  && !start;
            if (r_win_vld) begin
                for (int i = 0; i < 3; i++) begin
                    r_s1_lo[i]  <= w_s1_lo[i];
                    r_s1_mid[i] <= w_s1_mid[i];
                    r_s1_hi[i]  <= w_s1_hi[i];
                end
            end
            if (r_s1_vld) begin
                r_s2_a <= w_s2_a;
                r_s2_b <= w_s2_b;
                r_s2_c <= w_s2_c;
            end
            // median_out only moves together with a real result
            if (r_s2_vld && !start) begin
                r_median <= w_s3_med;
            end
        end
    end

    assign out_valid  = r_s3_vld;
    assign median_out = r_median;
    assign strip_done = r_s3_vld && r_s3_last;
    // DRAIN alone does not count: busy drops the edge after the last result
    assign busy       = w_open || w_pipe_vld;

endmodule
`default_nettype wire

// File: tb/tb_med_fil_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_med_fil_unit
// Description : Directed self-checking bench for med_fil_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_med_fil_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [4:0] col_top;
    logic [4:0] col_mid;
    logic [4:0] col_bot;
    logic       out_valid;
    logic [4:0] median_out;
    logic       strip_done;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int last_edge = 0;

    int q_val[$];
    int q_edge[$];
    int q_done[$];
    bit busy_hist[int];

    logic [4:0] pat_t [20];
    logic [4:0] pat_m [20];
    logic [4:0] pat_b [20];
    int         exp_med [18];

    med_fil_unit #(.BIT_LENGTH(5), .IMG_DIM(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .col_top    (col_top),
        .col_mid    (col_mid),
        .col_bot    (col_bot),
        .out_valid  (out_valid),
        .median_out (median_out),
        .strip_done (strip_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // observe outputs half a cycle after each edge
    always @(negedge clk) begin
        busy_hist[cyc_n] = busy;
        if (out_valid === 1'b1) begin
            q_val.push_back(int'(median_out));
            q_edge.push_back(cyc_n);
            q_done.push_back(int'(strip_done));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic iv,
                         input logic [4:0] t, input logic [4:0] m, input logic [4:0] b);
        start    = st;
        in_valid = iv;
        col_top  = t;
        col_mid  = m;
        col_bot  = b;
        @(posedge clk);
        #1;
        last_edge = cyc_n;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    function automatic int count_val(input int v);
        int c = 0;
        foreach (q_val[i]) if (q_val[i] == v) c++;
        return c;
    endfunction

    function automatic int count_done();
        int c = 0;
        foreach (q_done[i]) if (q_done[i] != 0) c++;
        return c;
    endfunction

    task automatic clear_q();
        q_val.delete();
        q_edge.delete();
        q_done.delete();
    endtask

    initial begin
        int e0;
        int s_edge;
        int k;
        int shift;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        col_top = '0; col_mid = '0; col_bot = '0;

        // pattern strip: salt windows, scrambled 1..9 window, then 7s
        for (int i = 0; i < 20; i++) begin
            pat_t[i] = 5'd7; pat_m[i] = 5'd7; pat_b[i] = 5'd7;
        end
        pat_t[0] = 0;  pat_m[0] = 0;  pat_b[0] = 0;
        pat_t[1] = 0;  pat_m[1] = 31; pat_b[1] = 0;
        pat_t[2] = 0;  pat_m[2] = 0;  pat_b[2] = 0;
        pat_t[3] = 31; pat_m[3] = 31; pat_b[3] = 31;
        pat_t[4] = 31; pat_m[4] = 0;  pat_b[4] = 31;
        pat_t[5] = 31; pat_m[5] = 31; pat_b[5] = 31;
        pat_t[6] = 9;  pat_m[6] = 1;  pat_b[6] = 5;
        pat_t[7] = 2;  pat_m[7] = 8;  pat_b[7] = 4;
        pat_t[8] = 7;  pat_m[8] = 3;  pat_b[8] = 6;
        exp_med = '{0, 0, 31, 31, 31, 8, 5, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};

        // ---- reset state
        #12;
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_median",     median_out, 0);
        chk("rst_strip_done", strip_done, 0);
        chk("rst_busy",       busy,       0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        idle(2);

        // ---- constant strip
        clear_q();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("const_busy_after_start", busy, 1);
        e0 = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
            if (i == 0) e0 = last_edge;
        end
        idle(8);
        chk("const_count",       q_val.size(), 18);
        chk("const_all_7",       count_val(7), 18);
        chk("const_first_lat",   q_edge[0], e0 + 5);
        chk("const_done_count",  count_done(), 1);
        chk("const_done_last",   q_done[17], 1);
        chk("const_busy_at_last",   busy_hist[q_edge[17]], 1);
        chk("const_busy_after_last", busy_hist[q_edge[17] + 1], 0);
        chk("const_busy_end",    busy, 0);

        // ---- salt noise + ordered window, gap-free
        clear_q();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, pat_t[i], pat_m[i], pat_b[i]);
        idle(8);
        chk("pat_count", q_val.size(), 18);
        for (int j = 0; j < 18; j++) chk($sformatf("pat_val[%0d]", j), q_val[j], exp_med[j]);
        chk("pat_done_last", q_done[17], 1);

        // ---- same strip with bubbles after columns 2, 10 and 19
        clear_q();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        e0 = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, pat_t[i], pat_m[i], pat_b[i]);
            if (i == 0) e0 = last_edge;
            if (i == 2 || i == 10 || i == 19) idle(1);
        end
        idle(8);
        chk("gap_count", q_val.size(), 18);
        for (int j = 0; j < 18; j++) begin
            k = j + 2;
            shift = ((k > 2) ? 1 : 0) + ((k > 10) ? 1 : 0);
            chk($sformatf("gap_val[%0d]", j),  q_val[j],  exp_med[j]);
            chk($sformatf("gap_edge[%0d]", j), q_edge[j], e0 + k + shift + 3);
        end
        chk("gap_done_count", count_done(), 1);

        // ---- abort: restart on column 12, then overrun the new strip
        clear_q();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
        drive(1'b1, 1'b1, 5'd20, 5'd20, 5'd20);
        s_edge = last_edge;
        for (int i = 1; i < 20; i++) drive(1'b0, 1'b1, 5'd20, 5'd20, 5'd20);
        drive(1'b0, 1'b1, 5'd1, 5'd1, 5'd1);
        drive(1'b0, 1'b1, 5'd1, 5'd1, 5'd1);
        idle(8);
        chk("abort_total",      q_val.size(), 25);
        chk("abort_old_count",  count_val(9), 7);
        chk("abort_new_count",  count_val(20), 18);
        chk("abort_ignored",    count_val(1), 0);
        chk("abort_new_first",  q_edge[7], s_edge + 5);
        chk("abort_done_count", count_done(), 1);
        chk("abort_done_last",  q_done[24], 1);

        // ---- asynchronous reset in the middle of RUN
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 5'd11, 5'd11, 5'd11);
        chk("arst_pre_valid",  out_valid,  1);
        chk("arst_pre_median", median_out, 11);
        in_valid = 1'b1; col_top = 5'd11; col_mid = 5'd11; col_bot = 5'd11;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid",  out_valid,  0);
        chk("arst_median",     median_out, 0);
        chk("arst_busy",       busy,       0);
        chk("arst_strip_done", strip_done, 0);
        clear_q();
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 5'd11, 5'd11, 5'd11);
        idle(5);
        chk("arst_no_output", q_val.size(), 0);
        chk("arst_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/med_fil_unit.md
# med_fil_unit

Streaming 3×3 median filter for the edge-detection pipeline's MED_FIL pass. It sits directly downstream of `Main_Ctrl_Unit`. While the controller is in LOAD_MOD, it streams one 3-pixel window column per cycle from a 3-row strip of the 20×20 image register file. The unit returns one 5-bit median per complete window, which the controller writes into its temp register file. The unit has a fixed latency and no backpressure.

## Interface
Parameters:
- `BIT_LENGTH`, default 5: pixel width.
- `IMG_DIM`, default 20: columns per strip. Each strip yields IMG_DIM−2 medians.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse that opens a new strip.
- `in_valid` input 1: a column is present on `col_top`/`col_mid`/`col_bot`.
- `col_top`, `col_mid`, `col_bot` input BIT_LENGTH each: rows r−2, r−1 and r of column c.
- `out_valid` output 1: `median_out` is valid this cycle.
- `median_out` output BIT_LENGTH: median of the 9-pixel window.
- `strip_done` output 1: pulses together with the strip's last `out_valid`.
- `busy` output 1: a strip is open or the pipeline holds valid data.

## Operation
- **State machine:** IDLE → FILL → RUN → DRAIN → IDLE.
  - `start` → FILL.
  - 3rd column accepted → RUN.
  - IMG_DIM-th column accepted → DRAIN.
  - Pipeline empty → IDLE.
- **Column counter `col_cnt`:**
  - Width ceil(log2(IMG_DIM+1)); cleared by `start`.
  - Increments on each accepted column and saturates at IMG_DIM.
- **Accepting a column:** a column is accepted when `in_valid`=1 in FILL or RUN. On acceptance, the window registers W[0..2] shift: W0←W1, W1←W2, W2←the incoming column.
- **Ignored columns:** `in_valid` in IDLE or DRAIN, or with `col_cnt`=IMG_DIM, is ignored.
- **Window tagging:** a window is tagged valid when the accepted column makes `col_cnt` ≥ 3.
- **Pipeline (3 registered stages, valid bit per stage):**
  - S1: sort each of the 3 window columns, giving (lo, mid, hi).
  - S2: compute a = max of the three lo values, b = med of the three mid values, c = min of the three hi values.
  - S3: `median_out` = med(a, b, c).
- **Arithmetic:** all comparisons are unsigned BIT_LENGTH. No widening; output width equals input width.
- **Gaps:** an `in_valid`=0 gap leaves the window frozen. Stages already in flight keep advancing and are never stalled.
- **`strip_done`:** pulses with the `out_valid` of the window ending at column IMG_DIM−1.
- **`start` while `busy`:**
  - Aborts the open strip.
  - Clears all three stage valid bits on the same edge, so no stale `out_valid` follows.
  - `col_cnt` restarts from 0.
- **`start` together with `in_valid`:** that column is accepted as column 0 of the new strip.
- **Outputs between results:** `median_out` holds its last value when `out_valid`=0.

## Timing
- **Reset values:**
  - `out_valid`=0, `median_out`=0, `strip_done`=0, `busy`=0.
  - State IDLE, `col_cnt`=0, window and stage registers 0.
- **Latency:** a column accepted on edge k that completes a valid window produces `out_valid`=1 after edge k+3 (3 cycles).
- **Throughput:** with contiguous `in_valid`, one median per cycle and IMG_DIM−2 per strip. The first result appears 5 cycles after the first column is accepted.
- **`busy`:**
  - Rises on the edge that samples `start`.
  - Falls on the edge after the final `out_valid`.
  - The controller must not leave LOAD_MOD while `busy`=1.
- **Reset mid-strip:** reset takes effect immediately and asynchronously. No output is produced for the partial strip.

## Structure
- **Shared package (`img_pkg`):**
  - IMG_DIM and BIT_LENGTH.
  - The MED_FIL/GAU_FIL/SOBEL/NON_MAX/HYSTER/QUANTIZE operation encodings.
  - The pixel typedef, so that `Main_Ctrl_Unit` and this unit agree.
- **Sub-module `sort3`:**
  - Purely combinational 3-input sorter producing (lo, mid, hi).
  - Instantiated 3× in S1 and reused for the med/min/max reductions in S2 and S3.

## Test plan
- **Constant strip:** all pixels 7, start plus 20 contiguous columns → 18 outputs, all 7. First `out_valid` 5 cycles after the first column; `strip_done` with the 18th output.
- **Salt noise:** window columns (0,0,0), (0,31,0), (0,0,0) → `median_out`=0. Columns (31,31,31), (31,0,31), (31,31,31) → `median_out`=31.
- **Ordered window:** pixels 1..9 scrambled across the columns as (9,1,5), (2,8,4), (7,3,6) → `median_out`=5.
- **Gaps:** insert an `in_valid`=0 bubble after each of columns 2, 10 and 19 → still exactly 18 outputs with values unchanged versus gap-free. `out_valid` shows bubbles at matching positions.
- **Abort:** `start` during column 12 with `in_valid`=1 → no further outputs from the old strip. The new strip's first output appears 5 cycles after that `start`; 21st and later `in_valid` columns are ignored.
- **Async reset:** assert `reset` mid-RUN between clock edges → outputs immediately 0 and `busy`=0. No `out_valid` after release until a new `start`.
